// File: rtl/memory_system_pkg.sv
// Shared address map and region decode for the cpu-side memory subsystem.
package memory_system_pkg;

   localparam logic [7:0] ROM_BASE  = 8'h00;
   localparam logic [7:0] RAM_BASE  = 8'h80;
   localparam logic [7:0] OUT_BASE  = 8'hE0;
   localparam logic [7:0] IN_BASE   = 8'hF0;
   localparam int         ROM_BYTES = 128;
   localparam int         RAM_DEPTH = 96;
   localparam int         N_PORTS   = 16;

   typedef enum logic [1:0] {
      REGION_ROM,
      REGION_RAM,
      REGION_OUT,
      REGION_IN
   } region_t;

   // Range compare on the upper address bits; the bases sit on 16/32-byte boundaries.
   function automatic region_t decodeRegion(input logic [7:0] addr);
      if (addr < RAM_BASE)      return REGION_ROM;
      else if (addr < OUT_BASE) return REGION_RAM;
      else if (addr < IN_BASE)  return REGION_OUT;
      else                      return REGION_IN;
   endfunction

endpackage

// File: rtl/memory_system_if.sv
// Cpu-side byte bus: address, write data and strobe out; registered read data back.
interface memory_system_if;
   logic [7:0] address;
   logic [7:0] data_in;
   logic       write;
   logic [7:0] data_out;

   modport master (output address, output data_in, output write, input data_out);
   modport slave  (input address, input data_in, input write, output data_out);
endinterface

// File: rtl/memory_system_io_ports.sv
// Output port registers with one-cycle write strobes, two-flop input synchronisers,
// and the readback mux for the I/O half of the address map.
module memory_system_io_ports
   import memory_system_pkg::*;
#(
   parameter logic [7:0] PORT_RESET = 8'h00
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 writeEn,
   input  logic [3:0]           portIdx,
   input  logic [7:0]           writeData,
   input  logic                 readInput,
   output logic [7:0]           readData,
   input  logic [N_PORTS*8-1:0] port_in,
   output logic [N_PORTS*8-1:0] port_out,
   output logic [N_PORTS-1:0]   port_strobe
);

   logic [N_PORTS-1:0][7:0] outReg;
   logic [N_PORTS-1:0][7:0] syncStage1;
   logic [N_PORTS-1:0][7:0] syncStage2;
   logic [N_PORTS-1:0]      strobeNext;

   always_comb begin
      strobeNext = '0;
      if (writeEn) strobeNext[portIdx] = 1'b1;
   end

   // port_in is asynchronous; only syncStage2 may be observed by the read path.
   always_ff @(posedge clk) begin
      if (reset) begin
         outReg      <= {N_PORTS{PORT_RESET}};
         syncStage1  <= '0;
         syncStage2  <= '0;
         port_strobe <= '0;
      end else begin
         if (writeEn) outReg[portIdx] <= writeData;
         syncStage1  <= port_in;
         syncStage2  <= syncStage1;
         port_strobe <= strobeNext;
      end
   end

   assign port_out = outReg;
   assign readData = readInput ? syncStage2[portIdx] : outReg[portIdx];

endmodule

// File: rtl/memory_system.sv
// Byte-addressed ROM/RAM/I-O subsystem behind the cpu bus. One registered read mux serves
// every region, so a write returns the old byte on the same edge (read-before-write).
module memory_system
   import memory_system_pkg::*;
#(
   parameter logic [7:0]             PORT_RESET = 8'h00,
   // ROM byte n lives at ROM_IMAGE[8n+7:8n].
   parameter logic [ROM_BYTES*8-1:0] ROM_IMAGE  = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   memory_system_if.slave       bus,
   input  logic [N_PORTS*8-1:0] port_in,
   output logic [N_PORTS*8-1:0] port_out,
   output logic [N_PORTS-1:0]   port_strobe
);

   region_t    region;
   logic [7:0] romOff;
   logic [7:0] ramOff;
   logic [7:0] romByte;
   logic [7:0] ramByte;
   logic [7:0] ioByte;
   logic [7:0] readByte;
   logic       unusedOffBits;
   logic [7:0] ram [RAM_DEPTH];

   assign region        = decodeRegion(bus.address);
   assign romOff        = bus.address - ROM_BASE;
   assign ramOff        = bus.address - RAM_BASE;
   assign unusedOffBits = ^{romOff[7], ramOff[7]};

   assign romByte = ROM_IMAGE[{romOff[6:0], 3'b000} +: 8];
   assign ramByte = ram[ramOff[6:0]];

   memory_system_io_ports #(
      .PORT_RESET (PORT_RESET)
   ) ioPorts (
      .clk         (clk),
      .reset       (reset),
      .writeEn     (bus.write && (region == REGION_OUT)),
      .portIdx     (bus.address[3:0]),
      .writeData   (bus.data_in),
      .readInput   (region == REGION_IN),
      .readData    (ioByte),
      .port_in     (port_in),
      .port_out    (port_out),
      .port_strobe (port_strobe)
   );

   always_comb begin
      readByte = '0;
      case (region)
         REGION_ROM: readByte = romByte;
         REGION_RAM: readByte = ramByte;
         default:    readByte = ioByte;
      endcase
   end

   // RAM contents survive reset; reset only blocks a write on the same edge.
   always_ff @(posedge clk) begin
      if (!reset && bus.write && (region == REGION_RAM)) ram[ramOff[6:0]] <= bus.data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) bus.data_out <= '0;
      else       bus.data_out <= readByte;
   end

endmodule

// File: tb/tb_memory_system.sv
// Directed bench for memory_system: hand-computed expectations for every region and boundary.
module tb_memory_system;

   localparam logic [1023:0] TB_ROM = (1024'h3E << (127 * 8)) | (1024'h5D << (16 * 8))
                                    | (1024'hAA << 8) | 1024'h86;

   logic         clk;
   logic         reset;
   logic [127:0] portIn;
   logic [127:0] portOut;
   logic [15:0]  portStrobe;
   int           nChecks;
   int           nFails;

   memory_system_if bus ();

   memory_system #(
      .PORT_RESET (8'h00),
      .ROM_IMAGE  (TB_ROM)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .port_in     (portIn),
      .port_out    (portOut),
      .port_strobe (portStrobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic [7:0] addr, input logic [7:0] data);
      bus.write   = wr;
      bus.address = addr;
      bus.data_in = data;
   endtask

   initial begin
      nChecks = 0;
      nFails  = 0;
      reset   = 1'b1;
      portIn  = '0;
      drive(1'b0, 8'h00, 8'h00);
      tick();
      tick();
      checkVal("rst_data_out", bus.data_out, 8'h00);
      checkVal("rst_port_out", portOut, 128'h0);
      checkVal("rst_strobe", portStrobe, 16'h0);

      // ROM reads, one cycle latency
      reset = 1'b0;
      drive(1'b0, 8'h00, 8'h00);
      tick();
      checkVal("rom_00", bus.data_out, 8'h86);
      drive(1'b0, 8'h01, 8'h00);
      tick();
      checkVal("rom_01", bus.data_out, 8'hAA);
      drive(1'b0, 8'h7F, 8'h00);
      tick();
      checkVal("rom_7f", bus.data_out, 8'h3E);

      // RAM write, read-before-write, readback
      drive(1'b1, 8'h80, 8'h11);
      tick();
      drive(1'b1, 8'h80, 8'h5A);
      tick();
      checkVal("ram_rbw_old", bus.data_out, 8'h11);
      drive(1'b0, 8'h80, 8'h00);
      tick();
      checkVal("ram_80", bus.data_out, 8'h5A);
      drive(1'b1, 8'hDF, 8'h77);
      tick();
      drive(1'b0, 8'hDF, 8'h00);
      tick();
      checkVal("ram_df", bus.data_out, 8'h77);

      // Output port write, strobe, readback
      drive(1'b1, 8'hE3, 8'hC3);
      tick();
      checkVal("port3_value", portOut, 128'hC3 << 24);
      checkVal("port3_strobe", portStrobe, 16'h0008);
      checkVal("port3_rbw_old", bus.data_out, 8'h00);
      drive(1'b0, 8'hE3, 8'h00);
      tick();
      checkVal("port3_strobe_off", portStrobe, 16'h0000);
      checkVal("port3_readback", bus.data_out, 8'hC3);

      // Back-to-back writes to port 0
      drive(1'b1, 8'hE0, 8'h01);
      tick();
      checkVal("b2b_strobe1", portStrobe, 16'h0001);
      drive(1'b1, 8'hE0, 8'h02);
      tick();
      checkVal("b2b_strobe2", portStrobe, 16'h0001);
      checkVal("b2b_value", portOut, (128'hC3 << 24) | 128'h02);
      drive(1'b1, 8'hEF, 8'h9E);
      tick();
      checkVal("port15_strobe", portStrobe, 16'h8000);
      checkVal("port15_value", portOut, (128'h9E << 120) | (128'hC3 << 24) | 128'h02);
      drive(1'b0, 8'hF0, 8'h00);
      tick();
      checkVal("port15_strobe_off", portStrobe, 16'h0000);

      // Input port synchroniser: two flops then the read register
      portIn[7:0] = 8'h3C;
      tick();
      checkVal("in0_edge1", bus.data_out, 8'h00);
      tick();
      checkVal("in0_edge2", bus.data_out, 8'h00);
      tick();
      checkVal("in0_edge3", bus.data_out, 8'h3C);
      portIn[127:120] = 8'hA5;
      drive(1'b0, 8'hFF, 8'h00);
      tick();
      tick();
      tick();
      checkVal("in15", bus.data_out, 8'hA5);

      // Writes to ROM and input-port regions are ignored
      drive(1'b1, 8'h10, 8'h00);
      tick();
      checkVal("rom_wr_strobe", portStrobe, 16'h0000);
      checkVal("rom_wr_old", bus.data_out, 8'h5D);
      drive(1'b0, 8'h10, 8'h00);
      tick();
      checkVal("rom_wr_kept", bus.data_out, 8'h5D);
      drive(1'b1, 8'hF5, 8'hFF);
      tick();
      checkVal("in_wr_strobe", portStrobe, 16'h0000);
      checkVal("in_wr_ports", portOut, (128'h9E << 120) | (128'hC3 << 24) | 128'h02);
      drive(1'b0, 8'hF5, 8'h00);
      tick();
      checkVal("in_wr_read", bus.data_out, 8'h00);

      // Reset wins over a concurrent port write; RAM survives
      reset = 1'b1;
      drive(1'b1, 8'hE0, 8'hFF);
      tick();
      checkVal("rstwr_port_out", portOut, 128'h0);
      checkVal("rstwr_strobe", portStrobe, 16'h0000);
      checkVal("rstwr_data_out", bus.data_out, 8'h00);
      reset = 1'b0;
      drive(1'b0, 8'h80, 8'h00);
      tick();
      checkVal("rstwr_ram_kept", bus.data_out, 8'h5A);
      checkVal("rstwr_strobe_after", portStrobe, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end

endmodule
